nios_128k_base_cpu_cpu_debug_slave_ocimem: RTL and testbench

- System-clock stage directly downstream of the debug-slave sysclk synchroniser.
- Consumes its single-cycle take_action_ocimem_a, take_action_ocimem_b and take_no_action_ocimem_a strobes plus the 38-bit jdo word.
- Turns them into read/write transactions on the on-chip debug (OCI) RAM.
- Returns the results as MonDReg, monitor_ready and monitor_error, which the tck side shifts back out to the host.

---
 rtl/nios_128k_base_cpu_cpu_debug_slave_ocimem.sv | 166 ++++++++++++++++
 tb/tb_nios_128k_base_cpu_cpu_debug_slave_ocimem.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nios_128k_base_cpu_cpu_debug_slave_ocimem.sv
// OCI RAM access engine for the debug slave (system clock side).
// Turns JTAG strobes into RAM reads/writes and returns monitor status.
module nios_128k_base_cpu_cpu_debug_slave_ocimem #(
  parameter int AW      = 8,
  parameter int TIMEOUT = 64
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          take_action_ocimem_a,
  input  logic          take_no_action_ocimem_a,
  input  logic          take_action_ocimem_b,
  input  logic [37:0]   jdo,
  output logic [AW-1:0] ram_addr,
  output logic [31:0]   ram_wdata,
  output logic          ram_rd,
  output logic          ram_wr,
  input  logic [31:0]   ram_rdata,
  input  logic          ram_ack,
  output logic [AW-1:0] MonAReg,
  output logic [31:0]   MonDReg,
  output logic          monitor_ready,
  output logic          monitor_error
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2
  } state_t;

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_t state_q, state_d;

  logic [7:0]    cnt_q, cnt_d;
  logic [AW-1:0] ram_addr_d;
  logic [31:0]   ram_wdata_d;
  logic          ram_rd_d, ram_wr_d;
  logic [AW-1:0] mon_a_d;
  logic [31:0]   mon_d_d;
  logic          rdy_d, err_d;

  logic [AW-1:0] jdo_addr;
  logic [AW-1:0] mon_a_inc;
  logic          any_strobe;
  logic          expired;
  logic          unused_bits;

  assign jdo_addr    = jdo[AW+16:17];
  assign mon_a_inc   = MonAReg + 1'b1;
  assign any_strobe  = take_action_ocimem_a | take_action_ocimem_b
                     | take_no_action_ocimem_a;
  assign expired     = (cnt_q == TO_LAST);
  assign unused_bits = ^{jdo[37:36], jdo[2:0]};

  // State register
  always_ff @(posedge clk) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next-state selection; strobe priority a > b > no-action
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (take_action_ocimem_a) begin
          if (jdo[34]) state_d = RD;
        end else if (take_action_ocimem_b) begin
          state_d = WR;
        end else if (take_no_action_ocimem_a) begin
          state_d = RD;
        end
      end
      RD, WR: begin
        if (ram_ack || expired) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Next values for the RAM request, monitor registers and timeout counter
  always_comb begin
    cnt_d       = cnt_q;
    ram_addr_d  = ram_addr;
    ram_wdata_d = ram_wdata;
    ram_rd_d    = ram_rd;
    ram_wr_d    = ram_wr;
    mon_a_d     = MonAReg;
    mon_d_d     = MonDReg;
    rdy_d       = monitor_ready;
    err_d       = monitor_error;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (take_action_ocimem_a) begin
          mon_a_d = jdo_addr;
          if (jdo[35]) err_d = 1'b0;
          if (jdo[34]) begin
            ram_addr_d = jdo_addr;
            ram_rd_d   = 1'b1;
            rdy_d      = 1'b0;
          end
        end else if (take_action_ocimem_b) begin
          ram_addr_d  = MonAReg;
          ram_wdata_d = jdo[34:3];
          ram_wr_d    = 1'b1;
          rdy_d       = 1'b0;
          mon_a_d     = mon_a_inc;
        end else if (take_no_action_ocimem_a) begin
          mon_a_d    = mon_a_inc;
          ram_addr_d = mon_a_inc;
          ram_rd_d   = 1'b1;
          rdy_d      = 1'b0;
        end
      end
      RD, WR: begin
        if (any_strobe) err_d = 1'b1;
        if (ram_ack) begin
          if (state_q == RD) mon_d_d = ram_rdata;
          ram_rd_d = 1'b0;
          ram_wr_d = 1'b0;
          rdy_d    = 1'b1;
        end else if (expired) begin
          ram_rd_d = 1'b0;
          ram_wr_d = 1'b0;
          rdy_d    = 1'b1;
          err_d    = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: begin
        ram_rd_d = 1'b0;
        ram_wr_d = 1'b0;
        rdy_d    = 1'b1;
      end
    endcase
  end

  // Registered outputs and timeout counter
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt_q         <= '0;
      ram_addr      <= '0;
      ram_wdata     <= '0;
      ram_rd        <= 1'b0;
      ram_wr        <= 1'b0;
      MonAReg       <= '0;
      MonDReg       <= '0;
      monitor_ready <= 1'b1;
      monitor_error <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      ram_addr      <= ram_addr_d;
      ram_wdata     <= ram_wdata_d;
      ram_rd        <= ram_rd_d;
      ram_wr        <= ram_wr_d;
      MonAReg       <= mon_a_d;
      MonDReg       <= mon_d_d;
      monitor_ready <= rdy_d;
      monitor_error <= err_d;
    end
  end

endmodule

// File: tb/tb_nios_128k_base_cpu_cpu_debug_slave_ocimem.sv
// Bench for the OCI RAM access engine.
// Expected requests and completions are queued by the stimulus.
module tb_nios_128k_base_cpu_cpu_debug_slave_ocimem;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        act_a = 1'b0;
  logic        noact_a = 1'b0;
  logic        act_b = 1'b0;
  logic [37:0] jdo = '0;
  logic [7:0]  ram_addr;
  logic [31:0] ram_wdata;
  logic        ram_rd, ram_wr;
  logic [31:0] ram_rdata = '0;
  logic        ram_ack = 1'b0;
  logic [7:0]  mon_a;
  logic [31:0] mon_d;
  logic        mon_rdy, mon_err;

  nios_128k_base_cpu_cpu_debug_slave_ocimem #(.AW(8), .TIMEOUT(64)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .take_action_ocimem_a(act_a),
    .take_no_action_ocimem_a(noact_a),
    .take_action_ocimem_b(act_b),
    .jdo(jdo),
    .ram_addr(ram_addr),
    .ram_wdata(ram_wdata),
    .ram_rd(ram_rd),
    .ram_wr(ram_wr),
    .ram_rdata(ram_rdata),
    .ram_ack(ram_ack),
    .MonAReg(mon_a),
    .MonDReg(mon_d),
    .monitor_ready(mon_rdy),
    .monitor_error(mon_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [7:0]  addr;
    logic [31:0] data;
  } req_t;

  typedef struct {
    logic [31:0] d;
    logic [7:0]  a;
    logic        e;
  } done_t;

  req_t  exp_req[$];
  done_t exp_done[$];
  int    exp_len[$];

  int checks = 0;
  int errors = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  function automatic logic [37:0] ja(logic [7:0] a, logic rd, logic clr);
    logic [37:0] j;
    j = '0;
    j[24:17] = a;
    j[34] = rd;
    j[35] = clr;
    return j;
  endfunction

  function automatic logic [37:0] jb(logic [31:0] d);
    logic [37:0] j;
    j = '0;
    j[34:3] = d;
    return j;
  endfunction

  function automatic req_t mk_req(logic w, logic [7:0] a, logic [31:0] d);
    req_t r;
    r.wr = w;
    r.addr = a;
    r.data = d;
    return r;
  endfunction

  function automatic done_t mk_done(logic [31:0] d, logic [7:0] a,
                                    logic e);
    done_t x;
    x.d = d;
    x.a = a;
    x.e = e;
    return x;
  endfunction

  // Called at a negedge; strobes are seen by the next posedge only
  task automatic strobe(logic a, logic b, logic n, logic [37:0] j);
    act_a = a;
    act_b = b;
    noact_a = n;
    jdo = j;
    @(negedge clk);
    act_a = 1'b0;
    act_b = 1'b0;
    noact_a = 1'b0;
    jdo = '0;
  endtask

  task automatic do_ack(int n, logic [31:0] d);
    repeat (n - 1) @(negedge clk);
    ram_ack = 1'b1;
    ram_rdata = d;
    @(negedge clk);
    ram_ack = 1'b0;
  endtask

  // Monitor: checks request launches, request lengths and completions
  logic prev_busy = 1'b0;
  logic prev_rdy = 1'b0;
  int   len = 0;

  always @(negedge clk) begin
    logic busy;
    req_t r;
    done_t x;
    int l;
    busy = ram_rd | ram_wr;
    if (!reset_n) begin
      len = 0;
    end else begin
      if (ram_rd && ram_wr) chk("rd_wr_both", 1, 0);
      if (busy && !prev_busy) begin
        len = 1;
        if (exp_req.size() == 0) begin
          chk("req_unexpected", {24'd0, ram_addr}, 32'hFFFF_FFFF);
        end else begin
          r = exp_req.pop_front();
          chk("req_kind", {31'd0, ram_wr}, {31'd0, r.wr});
          chk("req_addr", {24'd0, ram_addr}, {24'd0, r.addr});
          if (r.wr) chk("req_wdata", ram_wdata, r.data);
        end
      end else if (busy) begin
        len++;
      end else if (prev_busy) begin
        if (exp_len.size() == 0) begin
          chk("len_unexpected", len, 0);
        end else begin
          l = exp_len.pop_front();
          chk("req_len", len, l);
        end
      end
      if (mon_rdy && !prev_rdy) begin
        if (exp_done.size() == 0) begin
          chk("done_unexpected", 1, 0);
        end else begin
          x = exp_done.pop_front();
          chk("done_mond", mon_d, x.d);
          chk("done_mona", {24'd0, mon_a}, {24'd0, x.a});
          chk("done_err", {31'd0, mon_err}, {31'd0, x.e});
        end
      end
    end
    prev_busy = busy;
    prev_rdy = mon_rdy;
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_ready", {31'd0, mon_rdy}, 1);
    chk("rst_err", {31'd0, mon_err}, 0);
    chk("rst_rdwr", {30'd0, ram_rd, ram_wr}, 0);
    chk("rst_mona", {24'd0, mon_a}, 0);
    chk("rst_mond", mon_d, 0);
    chk("rst_ram", {ram_addr, 24'd0} | ram_wdata, 0);
    reset_n = 1'b1;
    @(negedge clk);

    // Single read, acked in the third cycle
    exp_req.push_back(mk_req(0, 8'h12, 0));
    exp_len.push_back(3);
    exp_done.push_back(mk_done(32'hDEADBEEF, 8'h12, 0));
    strobe(1, 0, 0, ja(8'h12, 1, 0));
    do_ack(3, 32'hDEADBEEF);
    @(negedge clk);

    // Streaming read
    exp_req.push_back(mk_req(0, 8'h40, 0));
    exp_len.push_back(1);
    exp_done.push_back(mk_done(32'hA5A50040, 8'h40, 0));
    strobe(1, 0, 0, ja(8'h40, 1, 0));
    do_ack(1, 32'hA5A50040);
    exp_req.push_back(mk_req(0, 8'h41, 0));
    exp_len.push_back(2);
    exp_done.push_back(mk_done(32'h5A5A0041, 8'h41, 0));
    strobe(0, 0, 1, '0);
    do_ack(2, 32'h5A5A0041);
    @(negedge clk);

    // Write stream wrapping through 0xFF
    strobe(1, 0, 0, ja(8'hFF, 0, 0));
    chk("seta_mona", {24'd0, mon_a}, 32'hFF);
    chk("seta_noreq", {31'd0, ram_rd}, 0);
    exp_req.push_back(mk_req(1, 8'hFF, 32'h11111111));
    exp_len.push_back(1);
    exp_done.push_back(mk_done(32'h5A5A0041, 8'h00, 0));
    strobe(0, 1, 0, jb(32'h11111111));
    do_ack(1, 32'h0);
    @(negedge clk);
    exp_req.push_back(mk_req(1, 8'h00, 32'h22222222));
    exp_len.push_back(2);
    exp_done.push_back(mk_done(32'h5A5A0041, 8'h01, 0));
    strobe(0, 1, 0, jb(32'h22222222));
    do_ack(2, 32'h0);
    @(negedge clk);
    chk("wrap_mona", {24'd0, mon_a}, 32'h01);

    // Timeout, stray ack in IDLE, then error clear
    exp_req.push_back(mk_req(0, 8'h80, 0));
    exp_len.push_back(64);
    exp_done.push_back(mk_done(32'h5A5A0041, 8'h80, 1));
    strobe(1, 0, 0, ja(8'h80, 1, 0));
    repeat (70) @(negedge clk);
    do_ack(1, 32'hBAD0BAD0);
    @(negedge clk);
    chk("idle_ack_mond", mon_d, 32'h5A5A0041);
    chk("idle_ack_rdy", {31'd0, mon_rdy}, 1);
    strobe(1, 0, 0, ja(8'h90, 0, 1));
    chk("clr_err", {31'd0, mon_err}, 0);
    chk("clr_mona", {24'd0, mon_a}, 32'h90);
    chk("clr_noreq", {30'd0, ram_rd, ram_wr}, 0);

    // Overrun during a write
    exp_req.push_back(mk_req(1, 8'h90, 32'h33333333));
    exp_len.push_back(3);
    exp_done.push_back(mk_done(32'h5A5A0041, 8'h91, 1));
    strobe(0, 1, 0, jb(32'h33333333));
    strobe(0, 1, 0, jb(32'h44444444));
    do_ack(2, 32'h0);
    @(negedge clk);
    chk("ovr_wdata", ram_wdata, 32'h33333333);

    // Priority: a over b, then b over no-action
    strobe(1, 0, 0, ja(8'h91, 0, 1));
    chk("clr2_err", {31'd0, mon_err}, 0);
    exp_req.push_back(mk_req(0, 8'h20, 0));
    exp_len.push_back(2);
    exp_done.push_back(mk_done(32'hCAFEF00D, 8'h20, 0));
    strobe(1, 1, 0, ja(8'h20, 1, 0));
    do_ack(2, 32'hCAFEF00D);
    @(negedge clk);
    exp_req.push_back(mk_req(1, 8'h20, 32'h13572468));
    exp_len.push_back(1);
    exp_done.push_back(mk_done(32'hCAFEF00D, 8'h21, 0));
    strobe(0, 1, 1, jb(32'h13572468));
    do_ack(1, 32'h0);
    @(negedge clk);

    // Ack arriving in the last timeout cycle wins
    exp_req.push_back(mk_req(0, 8'h50, 0));
    exp_len.push_back(64);
    exp_done.push_back(mk_done(32'h0F0F0F0F, 8'h50, 0));
    strobe(1, 0, 0, ja(8'h50, 1, 0));
    do_ack(64, 32'h0F0F0F0F);
    @(negedge clk);

    // Reset in the middle of a read with the error flag set
    exp_req.push_back(mk_req(0, 8'h33, 0));
    strobe(1, 0, 0, ja(8'h33, 1, 0));
    strobe(0, 1, 0, jb(32'h55555555));
    chk("pre_rst_err", {31'd0, mon_err}, 1);
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    chk("mid_rst_rd", {31'd0, ram_rd}, 0);
    chk("mid_rst_rdy", {31'd0, mon_rdy}, 1);
    chk("mid_rst_mona", {24'd0, mon_a}, 0);
    chk("mid_rst_mond", mon_d, 0);
    chk("mid_rst_err", {31'd0, mon_err}, 0);
    @(negedge clk);
    do_ack(1, 32'h77777777);
    @(negedge clk);
    chk("late_ack_mond", mon_d, 0);
    chk("late_ack_rdy", {31'd0, mon_rdy}, 1);
    chk("late_ack_rd", {31'd0, ram_rd}, 0);

    repeat (3) @(negedge clk);
    chk("req_q_left", exp_req.size(), 0);
    chk("len_q_left", exp_len.size(), 0);
    chk("done_q_left", exp_done.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
